store_unit: RTL and testbench

Store unit for the data-memory write path. It is the write-direction counterpart of the load unit whose output feeds the writeback mux. It takes the effective address from the immediate adder, the store data from rs2, and the store width, then issues a lane-aligned, byte-masked write to data memory through a valid/ready handshake. It stalls the pipeline while memory is not ready and aborts with a bus error after a bounded wait.

---
 rtl/store_unit_pkg.sv | 15 +
 rtl/store_lane_align.sv | 37 +++
 rtl/store_unit.sv | 117 +++++++++++
 tb/tb_store_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_unit_pkg.sv
// Shared store-path encodings: width codes, FSM states, default write timeout.
package store_unit_pkg;

    localparam logic [1:0] F3_SB = 2'b00;
    localparam logic [1:0] F3_SH = 2'b01;
    localparam logic [1:0] F3_SW = 2'b10;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

    localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/store_lane_align.sv
// Places store data on its byte lanes and builds the byte mask; flags misaligned/illegal widths.
// Purely combinational, no handshake.
module store_lane_align
    import store_unit_pkg::*;
(
    input  logic [1:0]  funct3_in,
    input  logic [1:0]  addr_lsb_in,
    input  logic [31:0] rs2_in,
    output logic [31:0] data_out,
    output logic [3:0]  mask_out,
    output logic        misaligned_out
);

    always_comb begin
        data_out       = 32'h0;
        mask_out       = 4'b0000;
        misaligned_out = 1'b0;
        case (funct3_in)
            F3_SB: begin
                data_out = {24'h0, rs2_in[7:0]} << {addr_lsb_in, 3'b000};
                mask_out = 4'b0001 << addr_lsb_in;
            end
            F3_SH: begin
                misaligned_out = addr_lsb_in[0];
                data_out       = addr_lsb_in[1] ? {rs2_in[15:0], 16'h0} : {16'h0, rs2_in[15:0]};
                mask_out       = addr_lsb_in[1] ? 4'b1100 : 4'b0011;
            end
            F3_SW: begin
                misaligned_out = |addr_lsb_in;
                data_out       = rs2_in;
                mask_out       = 4'b1111;
            end
            default: misaligned_out = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Data-memory store unit: registered write request 1 cycle after store_req_in.
// Stalls upstream while memory withholds ready; aborts with bus_err_out after TIMEOUT_CYCLES.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        store_req_in,
    input  logic [1:0]  funct3_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic        dm_ready_in,
    output logic [31:0] dm_addr_out,
    output logic [31:0] dm_data_out,
    output logic [3:0]  dm_mask_out,
    output logic        dm_wr_req_out,
    output logic        stall_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    mask_q, mask_d;
    logic          mis_q, mis_d;
    logic          err_q, err_d;
    logic          take_req;

    logic [31:0]   al_data;
    logic [3:0]    al_mask;
    logic          al_mis;

    store_lane_align u_align (
        .funct3_in      (funct3_in),
        .addr_lsb_in    (iadder_in[1:0]),
        .rs2_in         (rs2_in),
        .data_out       (al_data),
        .mask_out       (al_mask),
        .misaligned_out (al_mis)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        mask_d   = mask_q;
        mis_d    = 1'b0;
        err_d    = 1'b0;
        take_req = 1'b0;

        case (state_q)
            S_IDLE: take_req = store_req_in;
            S_WRITE: begin
                // Ready beats the timeout boundary; a request while stalled is ignored.
                if (dm_ready_in) begin
                    state_d  = S_IDLE;
                    take_req = store_req_in;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take_req) begin
            if (al_mis) begin
                mis_d = 1'b1;
            end else begin
                addr_d  = {iadder_in[31:2], 2'b00};
                data_d  = al_data;
                mask_d  = al_mask;
                cnt_d   = '0;
                state_d = S_WRITE;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            mask_q  <= 4'b0000;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign dm_addr_out    = addr_q;
    assign dm_data_out    = data_q;
    assign dm_mask_out    = mask_q;
    assign dm_wr_req_out  = (state_q == S_WRITE);
    assign stall_out      = (state_q == S_WRITE) & ~dm_ready_in;
    assign misaligned_out = mis_q;
    assign bus_err_out    = err_q;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the outstanding write.
module tb_store_unit;

    localparam int T = 4;

    logic        clk_in = 1'b0;
    logic        rst_in, store_req_in, dm_ready_in;
    logic [1:0]  funct3_in;
    logic [31:0] iadder_in, rs2_in;
    logic [31:0] dm_addr_out, dm_data_out;
    logic [3:0]  dm_mask_out;
    logic        dm_wr_req_out, stall_out, misaligned_out, bus_err_out;

    always #5 clk_in = ~clk_in;

    store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .store_req_in   (store_req_in),
        .funct3_in      (funct3_in),
        .iadder_in      (iadder_in),
        .rs2_in         (rs2_in),
        .dm_ready_in    (dm_ready_in),
        .dm_addr_out    (dm_addr_out),
        .dm_data_out    (dm_data_out),
        .dm_mask_out    (dm_mask_out),
        .dm_wr_req_out  (dm_wr_req_out),
        .stall_out      (stall_out),
        .misaligned_out (misaligned_out),
        .bus_err_out    (bus_err_out)
    );

    int checks   = 0;
    int failures = 0;

    // Model: one outstanding write (if any) and how long it has waited.
    bit          m_pend;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_mask;
    bit          m_mis, m_err;
    int          m_age;

    int stall_cnt, wr_cnt, err_at;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [1:0] f, input logic [31:0] a);
        return (f == 2'd0) || (f == 2'd1 && a % 2 == 0) || (f == 2'd2 && a % 4 == 0);
    endfunction

    task automatic model_load();
        int off, nb;
        logic [31:0] keep;
        off    = int'(iadder_in % 4);
        nb     = (funct3_in == 2'd0) ? 1 : (funct3_in == 2'd1) ? 2 : 4;
        keep   = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        m_addr = iadder_in - (iadder_in % 4);
        m_data = (rs2_in & keep) << (8 * off);
        m_mask = 4'(((1 << nb) - 1) << off);
        m_pend = 1'b1;
        m_age  = 0;
    endtask

    task automatic model_step();
        bit take;
        if (rst_in) begin
            m_pend = 0; m_addr = 0; m_data = 0; m_mask = 0;
            m_mis = 0; m_err = 0; m_age = 0;
        end else begin
            m_mis = 0;
            m_err = 0;
            take  = 0;
            if (!m_pend) begin
                take = store_req_in;
            end else if (dm_ready_in) begin
                m_pend = 0;
                take   = store_req_in;
            end else begin
                m_age++;
                if (m_age == T) begin
                    m_pend = 0;
                    m_err  = 1;
                end
            end
            if (take) begin
                if (legal(funct3_in, iadder_in)) model_load();
                else m_mis = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        chk("wr_req", dm_wr_req_out, m_pend);
        chk("misaligned", misaligned_out, m_mis);
        chk("bus_err", bus_err_out, m_err);
        if (m_pend) begin
            chk("addr", dm_addr_out, m_addr);
            chk("data", dm_data_out, m_data);
            chk("mask", dm_mask_out, m_mask);
        end
    endtask

    task automatic cycle();
        #1;
        chk("stall", stall_out, m_pend && !dm_ready_in);
        if (stall_out === 1'b1) stall_cnt++;
        model_step();
        @(posedge clk_in);
        #1;
        compare_outputs();
        if (dm_wr_req_out === 1'b1) wr_cnt++;
    endtask

    task automatic drive(input bit req, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] d, input bit rdy);
        store_req_in = req;
        funct3_in    = f;
        iadder_in    = a;
        rs2_in       = d;
        dm_ready_in  = rdy;
        cycle();
    endtask

    initial begin
        int mode;
        bit rdy;
        rst_in = 1; store_req_in = 0; funct3_in = 0; iadder_in = 0; rs2_in = 0; dm_ready_in = 0;
        m_pend = 0; m_age = 0; m_mis = 0; m_err = 0; m_addr = 0; m_data = 0; m_mask = 0;
        stall_cnt = 0; wr_cnt = 0; err_at = -1;
        @(negedge clk_in);
        drive(0, 2'd0, 32'h0, 32'h0, 0);
        drive(0, 2'd0, 32'h0, 32'h0, 0);
        chk("rst_addr", dm_addr_out, 32'h0);
        chk("rst_data", dm_data_out, 32'h0);
        chk("rst_mask", dm_mask_out, 4'h0);
        chk("rst_wr_req", dm_wr_req_out, 1'b0);
        chk("rst_stall", stall_out, 1'b0);
        rst_in = 0;

        // Byte store on lane 3.
        drive(1, 2'd0, 32'h1003, 32'hAABBCCDD, 1);
        chk("sb_addr", dm_addr_out, 32'h1000);
        chk("sb_data", dm_data_out, 32'hDD000000);
        chk("sb_mask", dm_mask_out, 4'b1000);
        chk("sb_wr_req", dm_wr_req_out, 1'b1);
        stall_cnt = 0;
        drive(0, 2'd0, 32'h0, 32'h0, 1);
        chk("sb_no_stall", stall_cnt, 0);

        // Half store to upper lanes, three wait cycles.
        drive(1, 2'd1, 32'h2002, 32'h12345678, 0);
        chk("sh_data", dm_data_out, 32'h56780000);
        chk("sh_mask", dm_mask_out, 4'b1100);
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) drive(0, 2'd0, 32'h0, 32'h0, 0);
        chk("sh_hold_data", dm_data_out, 32'h56780000);
        chk("sh_hold_addr", dm_addr_out, 32'h2000);
        drive(0, 2'd0, 32'h0, 32'h0, 1);
        chk("sh_stall_cycles", stall_cnt, 3);
        chk("sh_done", dm_wr_req_out, 1'b0);

        // Misaligned and illegal stores.
        drive(1, 2'd2, 32'h3001, 32'h1, 1);
        chk("sw_mis", misaligned_out, 1'b1);
        drive(1, 2'd1, 32'h3001, 32'h1, 1);
        chk("sh_mis", misaligned_out, 1'b1);
        drive(1, 2'd3, 32'h3000, 32'h1, 1);
        chk("ill_mis", misaligned_out, 1'b1);
        chk("ill_no_wr", dm_wr_req_out, 1'b0);
        drive(0, 2'd0, 32'h0, 32'h0, 1);
        chk("mis_pulse_end", misaligned_out, 1'b0);

        // Back-to-back word stores.
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'd2, 32'h4000 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1);
            chk("b2b_addr", dm_addr_out, 32'h4000 + 32'(4 * i));
        end
        drive(0, 2'd0, 32'h0, 32'h0, 1);
        chk("b2b_no_stall", stall_cnt, 0);

        // Timeout with ready never asserted.
        stall_cnt = 0; wr_cnt = 0; err_at = -1;
        drive(1, 2'd2, 32'h5000, 32'hDEADBEEF, 0);
        for (int i = 1; i <= 6; i++) begin
            drive(0, 2'd0, 32'h0, 32'h0, 0);
            if (bus_err_out === 1'b1 && err_at < 0) err_at = i;
        end
        chk("to_wr_cycles", wr_cnt, T);
        chk("to_err_at", err_at, T);
        chk("to_stall_cycles", stall_cnt, T);

        // Ready arriving on the last allowed cycle completes cleanly.
        drive(1, 2'd2, 32'h5100, 32'h1, 0);
        for (int i = 0; i < T - 1; i++) drive(0, 2'd0, 32'h0, 32'h0, 0);
        drive(0, 2'd0, 32'h0, 32'h0, 1);
        chk("edge_no_err", bus_err_out, 1'b0);
        chk("edge_done", dm_wr_req_out, 1'b0);

        // Reset during the second wait cycle abandons the write.
        drive(1, 2'd0, 32'h6001, 32'h55, 0);
        drive(0, 2'd0, 32'h0, 32'h0, 0);
        rst_in = 1;
        drive(0, 2'd0, 32'h0, 32'h0, 0);
        rst_in = 0;
        chk("rstw_wr_req", dm_wr_req_out, 1'b0);
        chk("rstw_err", bus_err_out, 1'b0);
        chk("rstw_data", dm_data_out, 32'h0);
        drive(1, 2'd0, 32'h6001, 32'h55, 1);
        chk("post_rst_data", dm_data_out, 32'h00005500);
        chk("post_rst_mask", dm_mask_out, 4'b0010);
        drive(0, 2'd0, 32'h0, 32'h0, 1);

        // Random traffic with phases of generous, sparse and absent ready.
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) mode = int'($urandom_range(0, 2));
            rdy    = (mode == 0) ? ($urandom_range(0, 9) != 0)
                   : (mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b0;
            rst_in = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom(), $urandom(), rdy);
        end
        rst_in = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
